// File: rtl/aligned_ram_ctrl.sv
// Purpose : single-port RAM with per-access size/alignment/range checking and error logging.
// Latency : one cycle from request acceptance to response (registered read data).
// Backpr. : one response register; req_ready = !rsp_valid || rsp_ready, so a stalled
//           response blocks new requests, and an unstalled one streams at one per cycle.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      request handshake
//   req_we, req_size         1 = write; size 0..3 = 1, 2, 4, 8 bytes
//   req_addr, req_wdata      byte address, right-justified write data
//   rsp_valid/rsp_ready      response handshake
//   rsp_rdata, rsp_err       right-justified read data (0 on write/error), reject flag
//   err_clr                  clears err_sticky and err_count
//   err_sticky, err_count    sticky reject flag, saturating reject counter
module aligned_ram_ctrl #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 256,
  parameter int ADDR_W    = 32,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [1:0]           req_size,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [DATA_W-1:0]    req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATA_W-1:0]    rsp_rdata,
  output logic                 rsp_err,
  input  logic                 err_clr,
  output logic                 err_sticky,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Storage is deliberately not reset.
  logic [DATA_W-1:0]    r_mem [DEPTH];

  logic                 r_rsp_valid;
  logic [DATA_W-1:0]    r_rsp_rdata;
  logic                 r_rsp_err;
  logic                 r_err_sticky;
  logic [ERR_CNT_W-1:0] r_err_count;

  logic                 w_accept;
  logic [OFF_W-1:0]     w_off;
  logic [ADDR_W-1:0]    w_word_idx;
  logic [IDX_W-1:0]     w_idx;
  logic [OFF_W-1:0]     w_align_mask;
  logic [NB-1:0]        w_lane_mask;
  logic [NB-1:0]        w_be;
  logic [DATA_W-1:0]    w_bit_mask;
  logic                 w_size_bad;
  logic                 w_misalign;
  logic                 w_oor;
  logic                 w_err;
  logic [DATA_W-1:0]    w_wdata_sh;
  logic [DATA_W-1:0]    w_rd_word;
  logic [DATA_W-1:0]    w_rd_data;
  logic [ERR_CNT_W-1:0] w_cnt_base;

  assign req_ready = !r_rsp_valid || rsp_ready;
  assign w_accept  = req_valid && req_ready;

  // Address decomposition: byte offset within the word and word index.
  assign w_off      = req_addr[OFF_W-1:0];
  assign w_word_idx = req_addr >> OFF_W;
  assign w_idx      = w_word_idx[IDX_W-1:0];

  // Size decode: alignment mask is BYTES-1 (truncated to the offset width),
  // lane mask covers BYTES lanes starting at lane 0.
  always_comb begin
    w_align_mask = '0;
    w_lane_mask  = '0;
    case (req_size)
      2'd0: begin
        w_align_mask = '0;
        w_lane_mask  = NB'(1);
      end
      2'd1: begin
        w_align_mask = OFF_W'(1);
        w_lane_mask  = NB'(3);
      end
      2'd2: begin
        w_align_mask = OFF_W'(3);
        w_lane_mask  = NB'(15);
      end
      default: begin
        w_align_mask = OFF_W'(7);
        w_lane_mask  = '1;
      end
    endcase
  end

  // Expand lane mask into a bit mask for read-data masking.
  always_comb begin
    w_bit_mask = '0;
    for (int b = 0; b < NB; b++) begin
      w_bit_mask[8*b +: 8] = {8{w_lane_mask[b]}};
    end
  end

  // Legality checks. An 8-byte access only exists on a 64-bit datapath.
  assign w_size_bad = (req_size == 2'd3) && (NB < 8);
  assign w_misalign = |(w_off & w_align_mask);
  assign w_oor      = (w_word_idx >= ADDR_W'(DEPTH));
  assign w_err      = w_size_bad || w_misalign || w_oor;

  // Write path: place low-order write bytes at lanes OFF..OFF+BYTES-1.
  assign w_be       = w_lane_mask << w_off;
  assign w_wdata_sh = req_wdata << {w_off, 3'b000};

  // Read path: index is guarded so an out-of-range address never reads past the array.
  assign w_rd_word = w_oor ? '0 : r_mem[w_idx];
  assign w_rd_data = (w_rd_word >> {w_off, 3'b000}) & w_bit_mask;

  always_ff @(posedge clk) begin
    if (w_accept && req_we && !w_err) begin
      for (int b = 0; b < NB; b++) begin
        if (w_be[b]) begin
          r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
        end
      end
    end
  end

  // Response register: loads on acceptance (even when the old response is
  // consumed in the same cycle), otherwise drains when consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_err   <= w_err;
      r_rsp_rdata <= (req_we || w_err) ? '0 : w_rd_data;
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  // Error log: a clear in the same cycle as an error applies first, so the
  // error is counted from zero.
  assign w_cnt_base = err_clr ? '0 : r_err_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_sticky <= 1'b0;
      r_err_count  <= '0;
    end else if (w_accept && w_err) begin
      r_err_sticky <= 1'b1;
      r_err_count  <= (&w_cnt_base) ? w_cnt_base : w_cnt_base + ERR_CNT_W'(1);
    end else if (err_clr) begin
      r_err_sticky <= 1'b0;
      r_err_count  <= '0;
    end
  end

  assign rsp_valid  = r_rsp_valid;
  assign rsp_rdata  = r_rsp_rdata;
  assign rsp_err    = r_rsp_err;
  assign err_sticky = r_err_sticky;
  assign err_count  = r_err_count;

endmodule
